serial_gray_sequencer: RTL



---
 rtl/gray_pkg.sv | 40 ++++
 rtl/full_adder.sv | 13 +
 rtl/serial_add_cell.sv | 31 +++
 rtl/serial_gray_sequencer.sv | 116 +++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared constants and types for the bit-serial RGB888 to grayscale path.
// The term table breaks each luma coefficient into shifted copies of its channel.
package gray_pkg;

    localparam int COEF_R  = 77;
    localparam int COEF_G  = 150;
    localparam int COEF_B  = 29;
    localparam int N_TERMS = 12;

    typedef enum logic [1:0] {CH_R, CH_G, CH_B} chan_e;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ADD, ST_DONE} state_e;

    typedef struct packed {
        chan_e      ch;
        logic [2:0] shift;
    } term_t;

    // 77 = 64+8+4+1, 150 = 128+16+4+2, 29 = 16+8+4+1
    function automatic term_t term_at(input logic [3:0] k);
        term_t t;
        case (k)
            4'd0:    t = '{CH_R, 3'd6};
            4'd1:    t = '{CH_R, 3'd3};
            4'd2:    t = '{CH_R, 3'd2};
            4'd3:    t = '{CH_R, 3'd0};
            4'd4:    t = '{CH_G, 3'd7};
            4'd5:    t = '{CH_G, 3'd4};
            4'd6:    t = '{CH_G, 3'd2};
            4'd7:    t = '{CH_G, 3'd1};
            4'd8:    t = '{CH_B, 3'd4};
            4'd9:    t = '{CH_B, 3'd3};
            4'd10:   t = '{CH_B, 3'd2};
            4'd11:   t = '{CH_B, 3'd0};
            default: t = '{CH_R, 3'd0};
        endcase
        return t;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_cell.sv
// Bit-serial adder: a full adder plus a carry flop; clear zeroes the carry
// before a new operand pair starts streaming.
module serial_add_cell (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);

    logic carry;

    full_adder u_fa (
        .a    (a),
        .b    (b),
        .cin  (carry),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk) begin
        if (rst || clear)
            carry <= 1'b0;
        else if (en)
            carry <= cout;
    end

endmodule

// File: rtl/serial_gray_sequencer.sv
// Sequences the serial add cell through the 12-term luma table, accumulating
// Y = (77R + 150G + 29B [+128]) LSB-first; result is acc[15:8].
module serial_gray_sequencer
    import gray_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter bit ROUND = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_r,
    input  logic [7:0] in_g,
    input  logic [7:0] in_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_gray,
    output logic       busy
);

    localparam int CNT_W = $clog2(ACC_W);

    state_e             state, state_nxt;
    logic [7:0]         r, g, b;
    logic [ACC_W-1:0]   acc, addend;
    logic [3:0]         k;
    logic [CNT_W-1:0]   bit_cnt;
    logic               sum, cout;
    logic               last_bit, last_term;
    term_t              term;
    logic [7:0]         chan_val;

    assign term      = term_at(k);
    assign last_bit  = bit_cnt == CNT_W'(ACC_W - 1);
    assign last_term = k == 4'(N_TERMS - 1);

    always_comb begin
        chan_val = r;
        case (term.ch)
            CH_G:    chan_val = g;
            CH_B:    chan_val = b;
            default: chan_val = r;
        endcase
    end

    serial_add_cell u_cell (
        .clk   (clk),
        .rst   (rst),
        .clear (state == ST_LOAD),
        .en    (state == ST_ADD),
        .a     (acc[0]),
        .b     (addend[0]),
        .sum   (sum),
        .cout  (cout)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_ADD;
            ST_ADD:  if (last_bit) state_nxt = last_term ? ST_DONE : ST_LOAD;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r       <= '0;
            g       <= '0;
            b       <= '0;
            acc     <= '0;
            addend  <= '0;
            k       <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    r   <= in_r;
                    g   <= in_g;
                    b   <= in_b;
                    acc <= ROUND ? ACC_W'(128) : '0;
                    k   <= '0;
                end
                ST_LOAD: begin
                    addend  <= ACC_W'(chan_val) << term.shift;
                    bit_cnt <= '0;
                end
                ST_ADD: begin
                    // Rotate: after ACC_W shifts the sum bits land back in place.
                    acc     <= {sum, acc[ACC_W-1:1]};
                    addend  <= addend >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last_bit && !last_term)
                        k <= k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = state == ST_IDLE;
    assign busy      = state != ST_IDLE;
    assign out_valid = state == ST_DONE;
    assign out_gray  = acc[15:8];

endmodule
